// File: rtl/reset_seq_pkg.sv
// Shared state encoding, reset-cause codes and counter helpers for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_WAIT_PERIPH,
        ST_GAP,
        ST_RUN
    } state_t;

    localparam logic [1:0] CAUSE_POR    = 2'b00;
    localparam logic [1:0] CAUSE_BUTTON = 2'b01;
    localparam logic [1:0] CAUSE_SOFT   = 2'b10;

    localparam int CNT_W = 8;

    // The timer is cleared on the edge a stage begins, so a stage of N edges ends when count == N-1.
    function automatic logic [CNT_W-1:0] last_count(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_timer.sv
// seq_timer: 8-bit saturating up-counter with synchronous clear, enable and compare-equal flag.
module seq_timer
    import reset_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] target,
    output logic             hit
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == target);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: peripherals, then bus/memory, then CPU, restartable by button or software.
// Optional ready-wait timeout is enabled by defining RSTSEQ_TIMEOUT_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES   = 16,
    parameter int STAGE_GAP     = 4,
    parameter int READY_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       drst,
    input  logic       sw_req,
    input  logic       periph_ready,
    output logic       periph_rst,
    output logic       bus_rst,
    output logic       cpu_rst,
    output logic       busy,
    output logic [1:0] cause,
    output logic       timeout
);

    state_t           state;
    state_t           state_d;
    logic             periph_d;
    logic             bus_d;
    logic             cpu_d;
    logic             busy_d;
    logic [1:0]       cause_d;
    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_hit;
    logic [CNT_W-1:0] tmr_target;
`ifdef RSTSEQ_TIMEOUT_EN
    logic             timeout_d;
`endif

    seq_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .target (tmr_target),
        .hit    (tmr_hit)
    );

    always_comb begin
        state_d    = state;
        periph_d   = periph_rst;
        bus_d      = bus_rst;
        cpu_d      = cpu_rst;
        busy_d     = busy;
        cause_d    = cause;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        tmr_target = last_count(HOLD_CYCLES);
`ifdef RSTSEQ_TIMEOUT_EN
        timeout_d  = timeout;
`endif

        case (state)
            ST_HOLD: begin
                if (tmr_hit) begin
                    state_d  = ST_WAIT_PERIPH;
                    periph_d = 1'b0;
                    tmr_clr  = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_WAIT_PERIPH: begin
                tmr_target = last_count(READY_TIMEOUT);
                if (periph_ready) begin
                    state_d = ST_GAP;
                    bus_d   = 1'b0;
                    tmr_clr = 1'b1;
                end
`ifdef RSTSEQ_TIMEOUT_EN
                else if (tmr_hit) begin
                    state_d   = ST_GAP;
                    bus_d     = 1'b0;
                    tmr_clr   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
`endif
            end
            ST_GAP: begin
                tmr_target = last_count(STAGE_GAP);
                if (tmr_hit) begin
                    state_d = ST_RUN;
                    cpu_d   = 1'b0;
                    busy_d  = 1'b0;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
            end
        endcase

        // A restart overrides whatever the stage logic decided; the button always wins.
        if (drst || ((state == ST_RUN) && sw_req)) begin
            state_d  = ST_HOLD;
            periph_d = 1'b1;
            bus_d    = 1'b1;
            cpu_d    = 1'b1;
            busy_d   = 1'b1;
            tmr_clr  = 1'b1;
            tmr_en   = 1'b0;
            cause_d  = drst ? CAUSE_BUTTON : CAUSE_SOFT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_HOLD;
            periph_rst <= 1'b1;
            bus_rst    <= 1'b1;
            cpu_rst    <= 1'b1;
            busy       <= 1'b1;
            cause      <= CAUSE_POR;
        end else begin
            state      <= state_d;
            periph_rst <= periph_d;
            bus_rst    <= bus_d;
            cpu_rst    <= cpu_d;
            busy       <= busy_d;
            cause      <= cause_d;
        end
    end

`ifdef RSTSEQ_TIMEOUT_EN
    // Sticky until power-on reset so software can see a peripheral failed to come up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout <= 1'b0;
        end else begin
            timeout <= timeout_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (HOLD_CYCLES=16, STAGE_GAP=4, READY_TIMEOUT=32).
module tb_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       drst;
    logic       sw_req;
    logic       periph_ready;
    logic       periph_rst;
    logic       bus_rst;
    logic       cpu_rst;
    logic       busy;
    logic [1:0] cause;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       drst;
        logic       swReq;
        logic       ready;
        logic [6:0] expOut;
    } vec_t;

    vec_t vecs[$];

    reset_sequencer #(
        .HOLD_CYCLES   (16),
        .STAGE_GAP     (4),
        .READY_TIMEOUT (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .drst         (drst),
        .sw_req       (sw_req),
        .periph_ready (periph_ready),
        .periph_rst   (periph_rst),
        .bus_rst      (bus_rst),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .cause        (cause),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] packOut();
        return {periph_rst, bus_rst, cpu_rst, busy, cause, timeout};
    endfunction

    task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got {p,b,c,busy,cause,to}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic addVec(input logic d, input logic s, input logic r,
                          input logic p, input logic b, input logic c,
                          input logic bz, input logic [1:0] cs);
        vec_t v;
        v.drst   = d;
        v.swReq  = s;
        v.ready  = r;
        v.expOut = {p, b, c, bz, cs, 1'b0};
        vecs.push_back(v);
    endtask

    // Full release after a restart edge: 16 hold edges, optional ready delay, bus, 4 gap edges, run.
    task automatic addRelease(input logic [1:0] cs, input int delay);
        for (int e = 1; e <= 15; e++) addVec(0, 0, 1, 1, 1, 1, 1, cs);
        addVec(0, 0, 1, 0, 1, 1, 1, cs);
        for (int k = 0; k < delay; k++) addVec(0, 1, 0, 0, 1, 1, 1, cs);
        addVec(0, 0, 1, 0, 0, 1, 1, cs);
        for (int k = 0; k < 3; k++) addVec(0, 0, 1, 0, 0, 1, 1, cs);
        addVec(0, 0, 1, 0, 0, 0, 0, cs);
    endtask

    task automatic applyStimulus(input vec_t v);
        drst         = v.drst;
        sw_req       = v.swReq;
        periph_ready = v.ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int periphEdge;
        int busEdge;

        rst          = 1'b0;
        drst         = 1'b0;
        sw_req       = 1'b0;
        periph_ready = 1'b1;

        // Power-on, then software restart, then simultaneous button+software.
        addRelease(2'b00, 0);
        addVec(0, 0, 1, 0, 0, 0, 0, 2'b00);
        addVec(0, 1, 1, 1, 1, 1, 1, 2'b10);
        addRelease(2'b10, 0);
        addVec(1, 1, 1, 1, 1, 1, 1, 2'b01);
        // Ignored sw_req in HOLD, then button mid-HOLD restarts the count.
        for (int e = 1; e <= 9; e++) addVec(0, (e == 5), 1, 1, 1, 1, 1, 2'b01);
        addVec(1, 0, 1, 1, 1, 1, 1, 2'b01);
        addRelease(2'b01, 5);
        // Button two edges after bus release: bus re-asserts and cpu never drops.
        addVec(0, 1, 1, 1, 1, 1, 1, 2'b10);
        for (int e = 1; e <= 15; e++) addVec(0, 0, 1, 1, 1, 1, 1, 2'b10);
        addVec(0, 0, 1, 0, 1, 1, 1, 2'b10);
        addVec(0, 0, 1, 0, 0, 1, 1, 2'b10);
        addVec(0, 0, 1, 0, 0, 1, 1, 2'b10);
        addVec(1, 0, 1, 1, 1, 1, 1, 2'b01);
        addRelease(2'b01, 0);
        addVec(0, 0, 1, 0, 0, 0, 0, 2'b01);

        #12;
        checkOutput("reset_state", packOut(), 7'b1111_000);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), packOut(), vecs[i].expOut);
        end

        // Asynchronous reset while waiting for peripherals.
        sw_req = 1'b1;
        @(posedge clk);
        #1;
        sw_req       = 1'b0;
        periph_ready = 1'b0;
        checkOutput("async_pre_restart", packOut(), 7'b1111_100);
        repeat (16) @(posedge clk);
        #1;
        checkOutput("async_in_wait", packOut(), 7'b0111_100);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_forced", packOut(), 7'b1111_000);

        // Peripherals never report ready.
        periphEdge = -1;
        busEdge    = -1;
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 1000; e++) begin
            @(posedge clk);
            #1;
            if (periphEdge < 0 && !periph_rst) periphEdge = e;
            if (busEdge < 0 && !bus_rst) busEdge = e;
        end
        checkValue("periph_fall_edge", periphEdge, 16);
`ifdef RSTSEQ_TIMEOUT_EN
        checkValue("timeout_bus_gap", busEdge - periphEdge, 32);
        checkOutput("timeout_run", packOut(), 7'b0000_001);
        sw_req = 1'b1;
        @(posedge clk);
        #1;
        sw_req = 1'b0;
        checkOutput("timeout_sticky", packOut(), 7'b1111_101);
`else
        checkValue("no_timeout_bus_edge", busEdge, -1);
        checkOutput("no_timeout_wait", packOut(), 7'b0111_000);
        sw_req = 1'b1;
        @(posedge clk);
        #1;
        sw_req = 1'b0;
        checkOutput("sw_ignored_in_wait", packOut(), 7'b0111_000);
        periph_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("late_ready", packOut(), 7'b0011_000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
